stoch_stream_gen: RTL and testbench

Stochastic number generator and stream controller that sits directly downstream of the team's full-period LFSR. The LFSR has the added-zero state, so it visits all 2^WIDTH values once per period. On a start pulse the block latches a binary operand, restarts the LFSR, and steps it for exactly 2^WIDTH cycles. Each cycle it emits one stochastic bit, (lfsr_data < operand), and optionally counts the ones so that the stream can be checked against the operand.

---
 rtl/stoch_pkg.sv | 19 +
 rtl/stoch_ones_counter.sv | 31 +++
 rtl/stoch_stream_gen.sv | 106 ++++++++++
 tb/tb_stoch_stream_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared types and sizing helpers for the stochastic stream generator.
// Pure declarations: no logic, no latency, no flow control.
package stoch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESTART = 2'd1,
      RUN     = 2'd2,
      DONE    = 2'd3
   } stoch_state_e;

   localparam int STOCH_WIDTH = 10;

   // One stream covers every state of a full-period (added-zero) LFSR.
   function automatic int STREAM_LEN(input int width);
      return 1 << width;
   endfunction

endpackage

// File: rtl/stoch_ones_counter.sv
// Counts ones in a stochastic stream; capture snapshots the count including the same-cycle increment.
// One-cycle latency from inc/capture to result; no backpressure, result holds until the next capture.
module stoch_ones_counter #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   input  logic             capture,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         result <= '0;
      end else begin
         if (clear)
            count <= '0;
         else if (inc)
            count <= count + WIDTH'(1);
         // Final bit arrives on the capture edge, so fold it in here.
         if (capture)
            result <= count + WIDTH'(inc);
      end
   end

endmodule

// File: rtl/stoch_stream_gen.sv
// Stochastic stream controller driving a full-period LFSR; bit = (lfsr_data < operand), one cycle of latency.
// No backpressure: a run streams 2^WIDTH bits back to back. STOCH_COUNT_EN adds the ones counter behind result.
module stoch_stream_gen
   import stoch_pkg::*;
#(
   parameter int WIDTH = STOCH_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] x_bin,
   input  logic [WIDTH-1:0] lfsr_data,
   output logic             lfsr_restart,
   output logic             lfsr_enable,
   output logic             busy,
   output logic             stream_bit,
   output logic             stream_valid,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] LAST_CYC = WIDTH'(STREAM_LEN(WIDTH) - 1);

   stoch_state_e     state;
   logic [WIDTH-1:0] cyc;
   logic [WIDTH-1:0] x_reg;

   logic accept;
   logic run_step;
   logic last;
   logic cmp;

   assign accept   = (state == IDLE) && start;
   // A RUN cycle only contributes a bit if it is not being cancelled.
   assign run_step = (state == RUN) && !abort;
   assign last     = (cyc == LAST_CYC);
   assign cmp      = (lfsr_data < x_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cyc          <= '0;
         x_reg        <= '0;
         stream_bit   <= 1'b0;
         stream_valid <= 1'b0;
         done         <= 1'b0;
      end else begin
         stream_valid <= run_step;
         stream_bit   <= run_step && cmp;
         done         <= run_step && last;

         case (state)
            IDLE: begin
               if (start) begin
                  x_reg <= x_bin;
                  state <= RESTART;
               end
            end
            RESTART: begin
               cyc <= '0;
               if (abort)
                  state <= IDLE;
               else
                  state <= RUN;
            end
            RUN: begin
               cyc <= cyc + WIDTH'(1);
               if (abort)
                  state <= IDLE;
               else if (last)
                  state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The LFSR samples these on the same edge the FSM advances, so they come straight from state.
   assign lfsr_restart = (state == RESTART);
   assign lfsr_enable  = (state == RUN);
   assign busy         = (state == RESTART) || (state == RUN);

`ifdef STOCH_COUNT_EN
   stoch_ones_counter #(
      .WIDTH (WIDTH)
   ) u_ones (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept),
      .inc     (run_step && cmp),
      .capture (run_step && last),
      .result  (result)
   );
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign result        = '0;
`endif

endmodule

// File: tb/tb_stoch_stream_gen.sv
// Bench for stoch_stream_gen: drives a 10-bit added-zero LFSR model and scoreboards every stream bit.
// Expected streams are precomputed from the LFSR sequence and the operand when each run is issued.
module tb_stoch_stream_gen;
   import stoch_pkg::*;

   localparam int W = 10;
   localparam int N = STREAM_LEN(W);

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] x_bin = '0;
   logic [W-1:0] lfsr_data;
   logic         lfsr_restart, lfsr_enable, busy, stream_bit, stream_valid, done;
   logic [W-1:0] result;

   int total = 0;
   int bad   = 0;
   int edge_cnt = 0;
   int e0 = 0;
   int ones_seen = 0;

   logic [W-1:0] lfsr_q;
   logic [W-1:0] seed = '0;

   typedef struct { bit b; int edge_no; } bit_rec_t;
   typedef struct { int edge_no; int res; int x; } done_rec_t;
   bit_rec_t  exp_bits[$];
   done_rec_t exp_done[$];
   int        exp_rst[$];

   stoch_stream_gen #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .x_bin        (x_bin),
      .lfsr_data    (lfsr_data),
      .lfsr_restart (lfsr_restart),
      .lfsr_enable  (lfsr_enable),
      .busy         (busy),
      .stream_bit   (stream_bit),
      .stream_valid (stream_valid),
      .done         (done),
      .result       (result)
   );

   always #5 clk = ~clk;

   // Fibonacci x^10+x^7+1 with the all-zero state spliced in after 10'b1000000000.
   function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] q);
      logic fb;
      fb = q[W-1] ^ q[6] ^ (q[W-2:0] == '0);
      return {q[W-2:0], fb};
   endfunction

   function automatic int exp_res(input int x);
`ifdef STOCH_COUNT_EN
      return x;
`else
      return 0;
`endif
   endfunction

   always @(posedge clk) edge_cnt++;

   always @(posedge clk or posedge reset) begin
      if (reset)             lfsr_q <= '0;
      else if (lfsr_restart) lfsr_q <= seed;
      else if (lfsr_enable)  lfsr_q <= lfsr_next(lfsr_q);
   end
   assign lfsr_data = lfsr_q;

   task automatic chk(input string name, input longint act, input longint expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents restart, a stream bit or done.
   always @(negedge clk) begin
      bit_rec_t  br;
      done_rec_t dr;
      if (!reset) begin
         if (lfsr_restart) begin
            chk("restart_expected", exp_rst.size() > 0, 1);
            if (exp_rst.size() > 0) chk("restart_cycle", edge_cnt, exp_rst.pop_front());
            ones_seen = 0;
         end
         if (stream_valid) begin
            chk("bit_expected", exp_bits.size() > 0, 1);
            if (exp_bits.size() > 0) begin
               br = exp_bits.pop_front();
               chk("stream_bit", stream_bit, br.b);
               chk("bit_cycle", edge_cnt, br.edge_no);
            end
            if (stream_bit) ones_seen++;
         end
         if (done) begin
            chk("done_expected", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) begin
               dr = exp_done.pop_front();
               chk("done_cycle", edge_cnt, dr.edge_no);
               chk("result", result, dr.res);
               chk("ones_count", ones_seen, dr.x);
               chk("last_bit_with_done", exp_bits.size(), 0);
            end
         end
      end
   end

   task automatic start_run(input logic [W-1:0] x, input logic [W-1:0] s, input bit with_abort);
      logic [W-1:0] v;
      @(posedge clk); #1;
      seed  = s;
      x_bin = x;
      start = 1'b1;
      abort = with_abort;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      x_bin = W'($urandom);
      e0 = edge_cnt;
      exp_rst.push_back(e0);
      v = s;
      for (int k = 0; k < N; k++) begin
         exp_bits.push_back('{(v < x), e0 + 2 + k});
         v = lfsr_next(v);
      end
      exp_done.push_back('{e0 + N + 1, exp_res(int'(x)), int'(x)});
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_done.size() != 0 && n < N + 100) begin
         @(posedge clk);
         n++;
      end
      chk("done_timeout", exp_done.size(), 0);
      chk("bits_drained", exp_bits.size(), 0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_lfsr_enable"}, lfsr_enable, 0);
      chk({tag, "_lfsr_restart"}, lfsr_restart, 0);
      chk({tag, "_stream_valid"}, stream_valid, 0);
      chk({tag, "_stream_bit"}, stream_bit, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      chk("reset_result", result, 0);
      reset = 1'b0;

      start_run(W'(300), W'(1), 1'b0);
      wait_done();
      repeat (3) @(posedge clk);
      #1 chk("result_hold", result, exp_res(300));

      start_run(W'(0), W'(1), 1'b0);
      wait_done();
      start_run(W'(1023), W'(1), 1'b0);
      wait_done();

      // start pulsed mid-run with a different operand must not disturb the stream
      start_run(W'(300), W'(1), 1'b0);
      repeat (50) @(posedge clk);
      #1 start = 1'b1; x_bin = W'(5);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();

      // abort at RUN cycle 100
      start_run(W'(777), W'($urandom_range(0, N - 1)), 1'b0);
      repeat (101) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      exp_bits.delete();
      exp_done.delete();
      chk_outputs_zero("abort");
      chk("abort_result_kept", result, exp_res(300));
      repeat (5) @(posedge clk);
      start_run(W'(512), W'($urandom_range(0, N - 1)), 1'b0);
      wait_done();

      // start and abort together in IDLE: start wins
      start_run(W'(123), W'($urandom_range(0, N - 1)), 1'b1);
      wait_done();

      for (int r = 0; r < 3; r++) begin
         start_run(W'($urandom_range(0, N - 1)), W'($urandom_range(0, N - 1)), 1'b0);
         wait_done();
      end

      // asynchronous reset in the middle of a run
      start_run(W'(400), W'(1), 1'b0);
      repeat (200) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk_outputs_zero("midrun_reset");
      chk("midrun_reset_result", result, 0);
      exp_bits.delete();
      exp_done.delete();
      exp_rst.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      chk_outputs_zero("post_reset");
      chk("post_reset_result", result, 0);

      start_run(W'(300), W'(1), 1'b0);
      wait_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
